// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock divider bank.
// Mode encoding and default sizing used by clk_div_chan and clk_div_bank.
package clk_div_pkg;

   localparam int CLK_DIV_CNT_W   = 25;
   localparam int CLK_DIV_DEF_DIV = 12;

   typedef enum logic {
      MODE_PULSE  = 1'b0,
      MODE_SQUARE = 1'b1
   } clk_div_mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor+mode, registered output.
// Pending settings are applied at a wrap so a running period is never cut short.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int CNT_W   = CLK_DIV_CNT_W,
   parameter int DEF_DIV = CLK_DIV_DEF_DIV
)
(
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             en_in,
   input  logic             sync_in,
   input  logic             ld_in,
   input  logic [CNT_W-1:0] div_in,
   input  logic             mode_in,
   output logic             clk_div_out
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

   logic [CNT_W-1:0] cnt, cur_div, pend_div;
   clk_div_mode_e    cur_mode, pend_mode;
   logic             pend_vld, out_q;

   logic             cur_ok, run, tc, xfer, nxt_ok, out_nxt;
   logic [CNT_W-1:0] nxt_div, cnt_nxt;
   clk_div_mode_e    nxt_mode;

   // SQUARE needs at least one high and one low cycle; any mode needs a nonzero divisor
   function automatic logic div_ok(input clk_div_mode_e m, input logic [CNT_W-1:0] d);
      return (m == MODE_SQUARE) ? (d >= TWO) : (d != '0);
   endfunction

   always_comb begin
      cur_ok   = div_ok(cur_mode, cur_div);
      run      = en_in && cur_ok;
      tc       = run && (cnt == cur_div - ONE);
      xfer     = pend_vld && (tc || !run || sync_in);
      nxt_div  = xfer ? pend_div  : cur_div;
      nxt_mode = xfer ? pend_mode : cur_mode;
      nxt_ok   = div_ok(nxt_mode, nxt_div);
      cnt_nxt  = '0;
      out_nxt  = 1'b0;
      if (sync_in || !run) begin
         cnt_nxt = '0;
         out_nxt = 1'b0;
      end else if (tc) begin
         // PULSE marks the old period's wrap; SQUARE starts the new period's high phase
         out_nxt = (cur_mode == MODE_PULSE) || nxt_ok;
      end else begin
         cnt_nxt = cnt + ONE;
         out_nxt = (cur_mode == MODE_SQUARE) && (cnt_nxt < (cur_div >> 1));
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt       <= '0;
         cur_div   <= DEF;
         pend_div  <= DEF;
         cur_mode  <= MODE_PULSE;
         pend_mode <= MODE_PULSE;
         pend_vld  <= 1'b0;
         out_q     <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         out_q    <= out_nxt;
         cur_div  <= nxt_div;
         cur_mode <= nxt_mode;
         // a load in the transfer cycle re-arms pending for the following wrap
         if (ld_in) begin
            pend_div  <= div_in;
            pend_mode <= clk_div_mode_e'(mode_in);
            pend_vld  <= 1'b1;
         end else if (xfer) begin
            pend_vld  <= 1'b0;
         end
      end
   end

   assign clk_div_out = out_q && !sync_in;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers with a shared load port and ack.
// Optional CLK_DIV_PHASE_SYNC_EN adds sync_in to realign all channels at once.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int CNT_W   = CLK_DIV_CNT_W,
   parameter  int DEF_DIV = CLK_DIV_DEF_DIV,
   localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)
(
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [NUM_CH-1:0] en_in,
   input  logic              load_in,
   input  logic [SEL_W-1:0]  ch_sel_in,
   input  logic [CNT_W-1:0]  div_in,
   input  logic              mode_in,
`ifdef CLK_DIV_PHASE_SYNC_EN
   input  logic              sync_in,
`endif
   output logic              load_ack_out,
   output logic [NUM_CH-1:0] clk_div_out
);

   logic [NUM_CH-1:0] ld_hit;
   logic              sync;

`ifdef CLK_DIV_PHASE_SYNC_EN
   assign sync = sync_in;
`else
   assign sync = 1'b0;
`endif

   // out-of-range selects match no channel, so they are dropped without an ack
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ld_hit[i] = load_in && (ch_sel_in == SEL_W'(i));

      clk_div_chan #(
         .CNT_W   (CNT_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk_in      (clk_in),
         .rst_n_in    (rst_n_in),
         .en_in       (en_in[i]),
         .sync_in     (sync),
         .ld_in       (ld_hit[i]),
         .div_in      (div_in),
         .mode_in     (mode_in),
         .clk_div_out (clk_div_out[i])
      );
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) load_ack_out <= 1'b0;
      else           load_ack_out <= |ld_hit;
   end

endmodule
